// File: rtl/tone_sequencer_if.sv
// Bus between the tone sequencer and its surroundings: control, note ROM port and audio sample handshake.
// The sequencer takes the slave view; the controller/ROM/audio side takes the master view.
interface tone_sequencer_if #(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 10,
  parameter int PERIOD_W = 20,
  parameter int TEMPO_W  = 27
);
  logic                       start;
  logic                       stop;
  logic [ADDR_W-1:0]          end_addr;
  logic [TEMPO_W-1:0]         tempo_limit;
  logic                       tempo_load;
  logic [NUM_CH-1:0]          ch_enable;
  logic [ADDR_W-1:0]          rom_addr;
  logic [NUM_CH*PERIOD_W-1:0] rom_data;
  logic                       sample_req;
  logic signed [31:0]         sample_out;
  logic                       sample_valid;
  logic                       playing;
  logic                       note_tick;

  modport master (
    output start, stop, end_addr, tempo_limit, tempo_load, ch_enable, rom_data, sample_req,
    input  rom_addr, sample_out, sample_valid, playing, note_tick
  );

  modport slave (
    input  start, stop, end_addr, tempo_limit, tempo_load, ch_enable, rom_data, sample_req,
    output rom_addr, sample_out, sample_valid, playing, note_tick
  );
endinterface

// File: rtl/tone_sequencer.sv
// Multi-channel square-wave note sequencer: walks a note ROM at a runtime tempo and mixes one tone per channel.
// Define TONE_SEQ_LOOP_EN to wrap back to address 0 at end_addr instead of returning to IDLE.
module tone_sequencer #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 10,
  parameter int PERIOD_W  = 20,
  parameter int TEMPO_W   = 27,
  parameter int AMP       = 1000000000,
  parameter int DEF_TEMPO = 9200000
) (
  input logic             CLOCK_50,
  input logic             reset,
  tone_sequencer_if.slave bus
);

  localparam int SHIFT = $clog2(NUM_CH);
  localparam int SUM_W = 32 + SHIFT;
  localparam logic signed [31:0]      CH_AMP      = $signed(32'(AMP)) >>> SHIFT;
  localparam logic signed [SUM_W-1:0] CH_AMP_X    = SUM_W'(CH_AMP);
  localparam logic [TEMPO_W-1:0]      DEF_TEMPO_V = TEMPO_W'(DEF_TEMPO);

  typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, PLAY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   romAddr_q, romAddr_d;
  logic [TEMPO_W-1:0]  pendingTempo_q, pendingTempo_d;
  logic [TEMPO_W-1:0]  activeTempo_q, activeTempo_d;
  logic [TEMPO_W-1:0]  durCnt_q, durCnt_d;
  logic [PERIOD_W-1:0] period_q [NUM_CH];
  logic [PERIOD_W-1:0] period_d [NUM_CH];
  logic [PERIOD_W-1:0] cnt_q [NUM_CH];
  logic [PERIOD_W-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0]   phase_q, phase_d;
  logic signed [31:0]  sampleOut_q, sampleOut_d;
  logic                sampleValid_q, sampleValid_d;

  logic signed [SUM_W-1:0] mixSum;
  logic signed [31:0]      mix;
  logic                    noteEnd;
  logic                    lastNote;

  assign noteEnd  = (state_q == PLAY) && (durCnt_q == activeTempo_q);
  assign lastNote = (romAddr_q == bus.end_addr);

  // Each channel is pre-scaled by 1/2^SHIFT, so the widened sum can never overflow 32 bits.
  always_comb begin
    mixSum = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if ((state_q == PLAY) && bus.ch_enable[k] && (period_q[k] != '0)) begin
        mixSum = phase_q[k] ? (mixSum - CH_AMP_X) : (mixSum + CH_AMP_X);
      end
    end
    mix = mixSum[31:0];
  end

  always_comb begin
    state_d        = state_q;
    romAddr_d      = romAddr_q;
    pendingTempo_d = pendingTempo_q;
    activeTempo_d  = activeTempo_q;
    durCnt_d       = durCnt_q;
    period_d       = period_q;
    cnt_d          = cnt_q;
    phase_d        = phase_q;
    sampleOut_d    = sampleOut_q;
    sampleValid_d  = bus.sample_req;

    if (bus.tempo_load) begin
      pendingTempo_d = bus.tempo_limit;
    end
    if (bus.sample_req) begin
      sampleOut_d = mix;
    end

    unique case (state_q)
      IDLE: begin
        for (int k = 0; k < NUM_CH; k++) begin
          cnt_d[k] = '0;
        end
        phase_d = '0;
        if (bus.start) begin
          romAddr_d = '0;
          state_d   = FETCH0;
        end
      end
      FETCH0: begin
        state_d = FETCH1;
      end
      // Tempo changes are only adopted here so a note is never stretched or cut mid-way.
      FETCH1: begin
        for (int k = 0; k < NUM_CH; k++) begin
          period_d[k] = bus.rom_data[k*PERIOD_W +: PERIOD_W];
          cnt_d[k]    = '0;
        end
        phase_d       = '0;
        activeTempo_d = pendingTempo_q;
        durCnt_d      = '0;
        state_d       = PLAY;
      end
      PLAY: begin
        durCnt_d = durCnt_q + 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
          if (period_q[k] == '0) begin
            cnt_d[k]   = '0;
            phase_d[k] = 1'b0;
          end else if (cnt_q[k] == period_q[k]) begin
            cnt_d[k]   = '0;
            phase_d[k] = ~phase_q[k];
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        if (noteEnd) begin
          durCnt_d = '0;
`ifdef TONE_SEQ_LOOP_EN
          romAddr_d = lastNote ? '0 : romAddr_q + 1'b1;
          state_d   = FETCH0;
`else
          if (lastNote) begin
            romAddr_d = '0;
            state_d   = IDLE;
          end else begin
            romAddr_d = romAddr_q + 1'b1;
            state_d   = FETCH0;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.stop) begin
      state_d   = IDLE;
      romAddr_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q        <= IDLE;
      romAddr_q      <= '0;
      pendingTempo_q <= DEF_TEMPO_V;
      activeTempo_q  <= DEF_TEMPO_V;
      durCnt_q       <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        period_q[k] <= '0;
        cnt_q[k]    <= '0;
      end
      phase_q       <= '0;
      sampleOut_q   <= '0;
      sampleValid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      romAddr_q      <= romAddr_d;
      pendingTempo_q <= pendingTempo_d;
      activeTempo_q  <= activeTempo_d;
      durCnt_q       <= durCnt_d;
      period_q       <= period_d;
      cnt_q          <= cnt_d;
      phase_q        <= phase_d;
      sampleOut_q    <= sampleOut_d;
      sampleValid_q  <= sampleValid_d;
    end
  end

  assign bus.rom_addr     = romAddr_q;
  assign bus.sample_out   = sampleOut_q;
  assign bus.sample_valid = sampleValid_q;
  assign bus.playing      = (state_q != IDLE);
  assign bus.note_tick    = noteEnd;

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Parametrised multi-channel square-wave note sequencer for the audio path.
- Steps through a note ROM at a programmable tempo. Each ROM word holds one half-period value per channel.
- Generates one square wave per channel, mixes the channels into a signed 32-bit sample, and presents it to the audio controller on each sample request.
- Supersedes the single-channel, fixed-tempo tone logic. Adds rests, per-channel enables, runtime tempo, start/stop and end-of-song handling.

Parameters:
- NUM_CH, 2, number of tone channels (1..8).
- ADDR_W, 10, note ROM address width.
- PERIOD_W, 20, per-channel half-period field width in the ROM word.
- TEMPO_W, 27, note-duration counter width.
- AMP, 1000000000, peak amplitude of a single channel before mixing (signed 32-bit).
- DEF_TEMPO, 9200000, tempo limit loaded at reset.

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse: begin playback from address 0
- stop  in  1  pulse: abort playback, return to IDLE
- end_addr  in  ADDR_W  last valid note address
- tempo_limit  in  TEMPO_W  new note-duration limit
- tempo_load  in  1  pulse: capture tempo_limit into the pending register
- ch_enable  in  NUM_CH  per-channel mute mask (1 = audible)
- rom_addr  out  ADDR_W  note ROM address
- rom_data  in  NUM_CH*PERIOD_W  ROM word; channel k is bits [k*PERIOD_W +: PERIOD_W]; 1-cycle read latency
- sample_req  in  1  audio controller ready for a sample (audio_out_allowed & audio_in_available)
- sample_out  out  32  signed mixed sample
- sample_valid  out  1  1-cycle pulse: sample_out updated
- playing  out  1  high in FETCH or PLAY
- note_tick  out  1  1-cycle pulse at each note boundary

Behaviour:
- Reset values:
  - state = IDLE; rom_addr = 0; sample_out = 0; sample_valid = 0; playing = 0; note_tick = 0.
  - All phase/tone counters = 0; active and pending tempo = DEF_TEMPO.
- FSM states: IDLE, FETCH0, FETCH1, PLAY.
  - IDLE: start → rom_addr <= 0, go to FETCH0.
  - FETCH0: ROM address presented, wait one cycle → FETCH1.
  - FETCH1: for every channel, latch the rom_data field into period[k], clear cnt[k], set phase[k] = 0. Copy pending tempo into active tempo and clear dur_cnt → PLAY.
  - PLAY: dur_cnt increments each cycle. When dur_cnt == active tempo:
    - note_tick pulses.
    - If rom_addr == end_addr: go to IDLE and return rom_addr to 0.
    - Otherwise rom_addr increments and the FSM goes to FETCH0.
  - Note length is therefore active tempo + 1 PLAY cycles, plus 2 fetch cycles.
- stop in any state → IDLE next cycle, rom_addr = 0. If start and stop arrive in the same cycle, stop wins. start outside IDLE is ignored.
- tempo_load: captured into the pending register at any time. It takes effect only at the next FETCH1, never mid-note.
- Per-channel tone, PLAY only:
  - If period[k] == 0, the channel is a rest: cnt and phase are held at 0 and the channel contributes 0.
  - Otherwise cnt increments. When cnt == period[k]: cnt <= 0 and phase toggles.
  - Half-period = period[k] + 1 cycles.
  - Counters freeze in FETCH0/FETCH1 and are cleared in IDLE.
- Mix:
  - Channel contribution = (ch_enable[k] && period[k] != 0 && state == PLAY) ? (phase[k] ? -(AMP >>> S) : +(AMP >>> S)) : 0, where S = clog2(NUM_CH).
  - Sum in 32+S bits, truncate to 32 bits. The >>>S scaling guarantees no overflow.
- Sample handshake:
  - On a cycle with sample_req = 1, the current mix is registered into sample_out and sample_valid pulses on the next cycle.
  - Without sample_req, sample_out holds its value. In IDLE the mix is 0.
- Reset mid-playback: all state returns to reset values on the next edge. Pending tempo is reloaded with DEF_TEMPO.

Optional Feature:
- Macro TONE_SEQ_LOOP_EN.
- Defined: at the end-of-song boundary (rom_addr == end_addr and dur_cnt == active tempo), rom_addr wraps to 0 and the FSM goes to FETCH0. Playback continues until stop. playing stays high.
- Undefined: at the same boundary the FSM returns to IDLE and playing drops.

Test Plan:
- NUM_CH=2, AMP=1000, DEF_TEMPO=9, ROM[0]={ch1=0, ch0=3}, end_addr=0, ch_enable=2'b11, start pulse → after 2 fetch cycles sample_out takes these values while sample_req is held high:
  - +500 for 4 samples, -500 for 4 samples, repeating.
  - After 10 PLAY cycles: note_tick = 1, then IDLE (loop off); sample_out settles to 0.
- ROM[0]={2,2}, ch_enable=2'b11 → sample_out alternates +1000 / -1000. With ch_enable=2'b01 → alternates +500 / -500.
- Playing 3 notes (end_addr=2), tempo_load with 4 asserted mid-note 0 → note 0 lasts 10 cycles; notes 1 and 2 last 5 PLAY cycles each.
- stop asserted during PLAY at address 1 → next cycle playing = 0, rom_addr = 0, sample_out becomes 0 at the next sample_req. Simultaneous start+stop in IDLE → stays IDLE.
- TONE_SEQ_LOOP_EN defined, end_addr=1 → rom_addr sequence 0,1,0,1…; playing never drops. Reset mid-note → sample_out=0 and rom_addr=0 next cycle.
- sample_req held low for 50 cycles → sample_out constant, sample_valid never asserted.
